// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared VGA geometry, coordinate widths and sprite-draw types.
// Revision: 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE = 1440;
  localparam int V_ACTIVE = 900;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;

  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  typedef logic [11:0] rgb12_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/sprite_draw_if.sv
`default_nettype none
// ============================================================================
// Module  : sprite_draw_if
// Brief   : Pixel coordinates, user controls and pixel colour of sprite_draw.
// Revision: 1.0 - initial release
// ============================================================================
interface sprite_draw_if;
  import vga_pkg::*;

  logic [X_W-1:0] curr_x;
  logic [Y_W-1:0] curr_y;
  rgb12_t         switch;
  logic           btn_up;
  logic           btn_down;
  logic           btn_left;
  logic           btn_right;
  logic           auto_mode;
  logic [3:0]     draw_r;
  logic [3:0]     draw_g;
  logic [3:0]     draw_b;

  modport master (
    output curr_x, curr_y, switch, btn_up, btn_down, btn_left, btn_right, auto_mode,
    input  draw_r, draw_g, draw_b
  );

  modport slave (
    input  curr_x, curr_y, switch, btn_up, btn_down, btn_left, btn_right, auto_mode,
    output draw_r, draw_g, draw_b
  );

endinterface : sprite_draw_if
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module  : sync2
// Brief   : Two-flop synchroniser for an asynchronous level, resets to 0.
// Revision: 1.0 - initial release
// ============================================================================
module sync2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule : sync2
`default_nettype wire

// File: rtl/sprite_draw.sv
`default_nettype none
// ============================================================================
// Module  : sprite_draw
// Brief   : Square sprite over flat background, moved once per frame either
//           manually from buttons or by bouncing off the active-area edges.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_draw
  import vga_pkg::*;
#(
  parameter int     SIZE   = 32,
  parameter int     STEP   = 4,
  parameter int     X_INIT = 704,
  parameter int     Y_INIT = 434,
  parameter rgb12_t BG_RGB = 12'h000
) (
  input wire logic    clk,
  input wire logic    rst,
  sprite_draw_if.slave bus
);

  localparam logic signed [11:0] c_STEP  = 12'(STEP);
  localparam logic signed [11:0] c_X_MAX = 12'(H_ACTIVE - SIZE);
  localparam logic signed [11:0] c_Y_MAX = 12'(V_ACTIVE - SIZE);
  localparam logic [11:0]        c_SIZE  = 12'(SIZE);

  // Bit order: {auto_mode, right, left, down, up}
  logic [4:0] w_async;
  logic [4:0] w_sync;

  assign w_async = {bus.auto_mode, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  generate
    for (genvar g = 0; g < 5; g++) begin : g_sync
      sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (w_async[g]),
        .o_q (w_sync[g])
      );
    end
  endgenerate

  logic w_up_s, w_down_s, w_left_s, w_right_s, w_auto_s;
  assign {w_auto_s, w_right_s, w_left_s, w_down_s, w_up_s} = w_sync;

  state_t         r_state;
  logic [X_W-1:0] r_pos_x;
  logic [Y_W-1:0] r_pos_y;
  logic           r_dir_x_neg;
  logic           r_dir_y_neg;
  logic [Y_W-1:0] r_prev_y;
  rgb12_t         r_draw;

  logic w_tick;
  assign w_tick = (bus.curr_y == '0) && (r_prev_y != '0);

  state_t w_next_state;
  assign w_next_state = w_tick ? (w_auto_s ? BOUNCE : MANUAL) : r_state;

  logic signed [11:0] w_dx, w_dy, w_sum_x, w_sum_y;
  logic [X_W-1:0]     w_new_x;
  logic [Y_W-1:0]     w_new_y;
  logic               w_hit_x, w_hit_y;

  // Movement uses the state selected on this tick, so a mode switch moves at once
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (w_next_state == BOUNCE) begin
      w_dx = r_dir_x_neg ? -c_STEP : c_STEP;
      w_dy = r_dir_y_neg ? -c_STEP : c_STEP;
    end else begin
      if (w_right_s && !w_left_s)      w_dx = c_STEP;
      else if (w_left_s && !w_right_s) w_dx = -c_STEP;
      if (w_down_s && !w_up_s)         w_dy = c_STEP;
      else if (w_up_s && !w_down_s)    w_dy = -c_STEP;
    end
  end

  assign w_sum_x = $signed({1'b0, r_pos_x}) + w_dx;
  assign w_sum_y = $signed({2'b00, r_pos_y}) + w_dy;

  always_comb begin
    w_new_x = w_sum_x[X_W-1:0];
    if (w_sum_x < 0)            w_new_x = '0;
    else if (w_sum_x > c_X_MAX) w_new_x = c_X_MAX[X_W-1:0];
    w_new_y = w_sum_y[Y_W-1:0];
    if (w_sum_y < 0)            w_new_y = '0;
    else if (w_sum_y > c_Y_MAX) w_new_y = c_Y_MAX[Y_W-1:0];
  end

  assign w_hit_x = (w_new_x == '0) || (w_new_x == c_X_MAX[X_W-1:0]);
  assign w_hit_y = (w_new_y == '0) || (w_new_y == c_Y_MAX[Y_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MANUAL;
      r_pos_x     <= X_W'(X_INIT);
      r_pos_y     <= Y_W'(Y_INIT);
      r_dir_x_neg <= 1'b0;
      r_dir_y_neg <= 1'b0;
      r_prev_y    <= '0;
    end else begin
      r_prev_y <= bus.curr_y;
      if (w_tick) begin
        r_state <= w_next_state;
        r_pos_x <= w_new_x;
        r_pos_y <= w_new_y;
        if (w_next_state == BOUNCE) begin
          if (w_hit_x) r_dir_x_neg <= ~r_dir_x_neg;
          if (w_hit_y) r_dir_y_neg <= ~r_dir_y_neg;
        end
      end
    end
  end

  logic w_inside;
  assign w_inside = ({1'b0, bus.curr_x} >= {1'b0, r_pos_x})
                 && ({1'b0, bus.curr_x} <  ({1'b0, r_pos_x} + c_SIZE))
                 && ({2'b00, bus.curr_y} >= {2'b00, r_pos_y})
                 && ({2'b00, bus.curr_y} <  ({2'b00, r_pos_y} + c_SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_draw <= '0;
    else     r_draw <= w_inside ? bus.switch : BG_RGB;
  end

  assign bus.draw_r = r_draw[11:8];
  assign bus.draw_g = r_draw[7:4];
  assign bus.draw_b = r_draw[3:0];

endmodule : sprite_draw
`default_nettype wire
